exe_muldiv_unit: RTL and testbench

- Multi-cycle RV32M multiply/divide unit in the EXE stage.
- Consumes the operands, rd address and funct3 that the ID/EXE pipeline register produces.
- Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU iteratively.
- Holds the pipeline through a combinational stall until the result is ready; the result and rd then feed the EXE/MEM register.

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_operand_prep.sv | 42 ++++
 rtl/exe_muldiv_unit.sv | 181 ++++++++++++++++++
 tb/tb_exe_muldiv_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
//   XLEN, RD_W       : operand/result width and destination address width
//   CNT_W            : iteration counter width (one iteration per result bit)
//   FUNCT_*          : funct3 encodings of the eight M-extension ops
//   FUNCT7_MULDIV    : funct7 value that marks an M-extension op for the decoder
//   muldiv_state_t   : unit FSM states
package muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RD_W  = 6;
  localparam int unsigned CNT_W = $clog2(XLEN);

  localparam logic [2:0] FUNCT_MUL    = 3'd0;
  localparam logic [2:0] FUNCT_MULH   = 3'd1;
  localparam logic [2:0] FUNCT_MULHSU = 3'd2;
  localparam logic [2:0] FUNCT_MULHU  = 3'd3;
  localparam logic [2:0] FUNCT_DIV    = 3'd4;
  localparam logic [2:0] FUNCT_DIVU   = 3'd5;
  localparam logic [2:0] FUNCT_REM    = 3'd6;
  localparam logic [2:0] FUNCT_REMU   = 3'd7;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_operand_prep.sv
// Combinational operand preparation for the multiply/divide unit.
// Converts operands to unsigned magnitudes and reports their signs, plus the
// divide special cases that bypass the iterative datapath.
//   funct3            in  : op select
//   rs1_data/rs2_data in  : raw operands
//   mag_a/mag_b       out : operand magnitudes
//   sign_a/sign_b     out : operand is treated as signed and is negative
//   div_zero          out : divide/remainder op with zero divisor
//   div_ovf           out : signed divide of most-negative value by -1
module muldiv_operand_prep
  import muldiv_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] mag_a,
  output logic [XLEN-1:0] mag_b,
  output logic            sign_a,
  output logic            sign_b,
  output logic            div_zero,
  output logic            div_ovf
);

  logic is_div;
  logic signed_a;
  logic signed_b;

  always_comb begin
    is_div   = funct3[2];
    // MUL keeps only the low half, which is sign-agnostic, so it runs unsigned.
    signed_a = funct3 inside {FUNCT_MULH, FUNCT_MULHSU, FUNCT_DIV, FUNCT_REM};
    signed_b = funct3 inside {FUNCT_MULH, FUNCT_DIV, FUNCT_REM};
    sign_a   = signed_a & rs1_data[XLEN-1];
    sign_b   = signed_b & rs2_data[XLEN-1];
    mag_a    = sign_a ? -rs1_data : rs1_data;
    mag_b    = sign_b ? -rs2_data : rs2_data;
    div_zero = is_div && (rs2_data == '0);
    div_ovf  = is_div && signed_b && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
               (rs2_data == '1);
  end

endmodule

// File: rtl/exe_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit in the EXE stage.
// Multiplies use radix-2 shift-add, divides use restoring division, one bit per
// cycle over 32 CALC cycles. Divide-by-zero and signed overflow finish in one
// cycle. Build option MULDIV_FAST_MUL_EN gives all multiplies a single-cycle
// combinational product on the same one-cycle path.
//   clk, rst     in  : clock, asynchronous active-high reset
//   start        in  : M-extension op present in EXE
//   funct3       in  : op select
//   rs1_data     in  : operand A
//   rs2_data     in  : operand B
//   rd_addr      in  : destination of the op
//   flush        in  : kill of the EXE instruction
//   stall        out : hold PC, IF/ID and ID/EXE
//   done         out : one-cycle result-valid pulse
//   result       out : result, qualify with done
//   rd_addr_out  out : destination captured at start
module exe_muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [RD_W-1:0] rd_addr,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [RD_W-1:0] rd_addr_out
);

  muldiv_state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       funct3_q;
  logic             sign_a_q, sign_b_q;
  logic [XLEN-1:0]  divisor_q;
  // hi: product upper half / partial remainder; lo: multiplier / dividend-quotient
  logic [XLEN-1:0]  hi_q, lo_q;
  logic [XLEN-1:0]  result_q;
  logic [RD_W-1:0]  rd_q;

  logic [XLEN-1:0] mag_a, mag_b;
  logic            sign_a, sign_b, div_zero, div_ovf;

  muldiv_operand_prep u_prep (
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .mag_a    (mag_a),
    .mag_b    (mag_b),
    .sign_a   (sign_a),
    .sign_b   (sign_b),
    .div_zero (div_zero),
    .div_ovf  (div_ovf)
  );

  logic            accept;
  logic            fast_path;
  logic [XLEN-1:0] fast_result;

  assign accept = (state_q == IDLE) && start && !flush;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] ext_a, ext_b, fast_prod;
  // Low 2*XLEN bits of the 33x33 signed product, computed on sign-extended copies.
  assign ext_a     = {{XLEN{sign_a}}, rs1_data};
  assign ext_b     = {{XLEN{sign_b}}, rs2_data};
  assign fast_prod = ext_a * ext_b;
  assign fast_path = div_zero | div_ovf | !funct3[2];
`else
  assign fast_path = div_zero | div_ovf;
`endif

  always_comb begin
    fast_result = '0;
    if (div_zero) begin
      fast_result = funct3[1] ? rs1_data : '1;
    end else if (div_ovf) begin
      fast_result = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (!funct3[2]) begin
      fast_result = (funct3 == FUNCT_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif
  end

  // One iteration of the datapath.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [XLEN-1:0]   hi_n, lo_n;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;
  logic [XLEN-1:0]   calc_result;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? divisor_q : '0)};
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, divisor_q};
    // Only used when div_ge, where the difference always fits in XLEN bits.
    div_diff  = div_shift[XLEN-1:0] - divisor_q;
    if (funct3_q[2]) begin
      hi_n = div_ge ? div_diff : div_shift[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], div_ge};
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    end

    prod     = {hi_n, lo_n};
    prod_fix = (sign_a_q ^ sign_b_q) ? -prod : prod;
    quot_fix = (sign_a_q ^ sign_b_q) ? -lo_n : lo_n;
    rem_fix  = sign_a_q ? -hi_n : hi_n;

    if (funct3_q[2]) begin
      calc_result = funct3_q[1] ? rem_fix : quot_fix;
    end else begin
      calc_result = (funct3_q == FUNCT_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = fast_path ? DONE : CALC;
      CALC:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;

    stall = !flush && (((state_q == IDLE) && start) || (state_q == CALC));
    done  = !flush && (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      funct3_q  <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      divisor_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      result_q  <= '0;
      rd_q      <= '0;
    end else if (accept) begin
      cnt_q     <= CNT_W'(XLEN - 1);
      funct3_q  <= funct3;
      sign_a_q  <= sign_a;
      sign_b_q  <= sign_b;
      divisor_q <= mag_b;
      hi_q      <= '0;
      lo_q      <= mag_a;
      rd_q      <= rd_addr;
      if (fast_path) result_q <= fast_result;
    end else if ((state_q == CALC) && !flush) begin
      cnt_q <= cnt_q - 1'b1;
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      if (cnt_q == '0) result_q <= calc_result;
    end
  end

  assign result      = result_q;
  assign rd_addr_out = rd_q;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Randomized scoreboard bench for exe_muldiv_unit: the driver pushes the
// reference-model result for every accepted op, an independent monitor pops
// and compares on each done pulse.
module tb_exe_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [5:0]  rd_addr;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic [5:0]  rd_addr_out;

  exe_muldiv_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .funct3      (funct3),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .rd_addr     (rd_addr),
    .flush       (flush),
    .stall       (stall),
    .done        (done),
    .result      (result),
    .rd_addr_out (rd_addr_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [5:0]  rd;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: RV32M semantics via wide integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ub = longint'({32'b0, b});
    logic [63:0] p;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding op.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b0 && done === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("spurious_done", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("result", 64'(result), 64'(e.res));
          check("rd_addr_out", 64'(rd_addr_out), 64'(e.rd));
        end
      end
    end
  end

  // Issue one op; poke re-asserts start mid-CALC, which must be ignored.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] rd, input bit poke);
    exp_t e;
    int   lat = exp_latency(f, a, b);
    int   c;
    bit   seen = 1'b0;
    bit   stall_ok = 1'b1;
    @(negedge clk);
    start = 1'b1; flush = 1'b0; funct3 = f; rs1_data = a; rs2_data = b; rd_addr = rd;
    e.res = ref_model(f, a, b);
    e.rd  = rd;
    sb_q.push_back(e);
    #1;
    if (stall !== 1'b1) stall_ok = 1'b0;
    @(posedge clk);
    for (c = 1; c <= 100; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && c == 5) begin
        start = 1'b1; funct3 = 3'($urandom_range(0, 7)); rs1_data = $urandom;
        rs2_data = $urandom; rd_addr = ~rd;
      end
      #1;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (stall !== 1'b1) stall_ok = 1'b0;
    end
    if (seen) check("latency", 64'(c), 64'(lat));
    else check("done_timeout", 64'd0, 64'd1);
    check("stall_in_done", 64'(stall), 64'd0);
    check("stall_while_busy", 64'(stall_ok), 64'd1);
  endtask

  // Start an op that is never expected to complete, and return after n CALC cycles.
  task automatic start_untracked(input int n);
    @(negedge clk);
    start = 1'b1; flush = 1'b0; funct3 = 3'd5; rs1_data = 32'd123456; rs2_data = 32'd7;
    rd_addr = 6'd33;
    @(posedge clk);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0;
    rs1_data = '0; rs2_data = '0; rd_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_rd", 64'(rd_addr_out), 64'd0);
    rst = 1'b0;

    run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 6'd5, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd6, 1'b0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd7, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 6'd8, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 6'd9, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 6'd10, 1'b0);
    run_op(3'd5, 32'd100, 32'd7, 6'd11, 1'b0);
    run_op(3'd7, 32'd100, 32'd7, 6'd42, 1'b0);
    run_op(3'd4, 32'd5, 32'd0, 6'd12, 1'b0);
    run_op(3'd6, 32'd5, 32'd0, 6'd13, 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 6'd14, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 6'd15, 1'b0);

    // Flush in CALC cycle 10: no done, stall drops immediately.
    start_untracked(10);
    flush = 1'b1;
    #1;
    check("flush_stall", 64'(stall), 64'd0);
    check("flush_done", 64'(done), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("post_flush_stall", 64'(stall), 64'd0);
    check("post_flush_done", 64'(done), 64'd0);
    run_op(3'd5, 32'd1000, 32'd3, 6'd16, 1'b0);

    // start during CALC is ignored: the monitor flags any extra done.
    run_op(3'd7, 32'hDEAD_BEEF, 32'd77, 6'd17, 1'b1);
    run_op(3'd0, 32'd1234, 32'd5678, 6'd18, 1'b1);

    // Async reset in CALC cycle 5.
    start_untracked(5);
    rst = 1'b1;
    #1;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_rd", 64'(rd_addr_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_op(3'd6, 32'hFFFF_FF00, 32'd9, 6'd19, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
             6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
